// File: rtl/me_stage_if.sv
// rtl/me_stage_if.sv - EX->ME->WB handshake and bus bundle for the memory-access stage
interface me_stage_if;
  logic        ES_Valid;
  logic        ME_Unit_Ready;
  logic [73:0] EX_to_ME_Bus;
  logic [31:0] data_sram_rdata;
  logic        ME_Valid;
  logic        WB_Unit_Ready;
  logic [69:0] ME_to_WB_Bus;
  logic [37:0] ME_to_ID_Bypass;

  // master: the memory-access stage itself
  modport master (
    input  ES_Valid,
    output ME_Unit_Ready,
    input  EX_to_ME_Bus,
    input  data_sram_rdata,
    output ME_Valid,
    input  WB_Unit_Ready,
    output ME_to_WB_Bus,
    output ME_to_ID_Bypass
  );

  // slave: the surrounding pipeline (execute, SRAM, write-back, decode)
  modport slave (
    output ES_Valid,
    input  ME_Unit_Ready,
    output EX_to_ME_Bus,
    output data_sram_rdata,
    input  ME_Valid,
    output WB_Unit_Ready,
    input  ME_to_WB_Bus,
    input  ME_to_ID_Bypass
  );
endinterface

// File: rtl/me_stage.sv
// rtl/me_stage.sv - memory-access pipeline stage; define ME_FWD_EN to forward final_result on the bypass bus
module me_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  me_stage_if.master  bus_if
);

  // load_op encodings
  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_H  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  logic        me_valid_q, me_valid_d;
  logic [31:0] pc_q, pc_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  dest_q, dest_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic        res_from_mem_q, res_from_mem_d;
  logic [2:0]  load_op_q, load_op_d;

  logic        ready_go;
  logic        me_ready;
  logic        accept;
  logic [1:0]  addr;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_result;
  logic [31:0] final_result;
  logic        wr_valid;

  // SRAM data arrives while the instruction sits in ME, so the stage never waits
  assign ready_go = 1'b1;

  // Free when empty or when write-back drains us this cycle; independent of ES_Valid
  assign me_ready = ~me_valid_q | (ready_go & bus_if.WB_Unit_Ready);
  assign accept   = bus_if.ES_Valid & me_ready;

  assign bus_if.ME_Unit_Ready = me_ready;
  assign bus_if.ME_Valid      = me_valid_q;

  // Next-state: load a new instruction (or bubble) whenever the slot frees up
  always_comb begin
    me_valid_d     = me_valid_q;
    pc_d           = pc_q;
    rf_we_d        = rf_we_q;
    dest_d         = dest_q;
    alu_result_d   = alu_result_q;
    res_from_mem_d = res_from_mem_q;
    load_op_d      = load_op_q;
    if (me_ready) begin
      me_valid_d = bus_if.ES_Valid;
    end
    if (accept) begin
      pc_d           = bus_if.EX_to_ME_Bus[73:42];
      rf_we_d        = bus_if.EX_to_ME_Bus[41];
      dest_d         = bus_if.EX_to_ME_Bus[40:36];
      alu_result_d   = bus_if.EX_to_ME_Bus[35:4];
      res_from_mem_d = bus_if.EX_to_ME_Bus[3];
      load_op_d      = bus_if.EX_to_ME_Bus[2:0];
    end
  end

  // Stage register with synchronous reset; reset also drops any stalled instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      me_valid_q     <= 1'b0;
      pc_q           <= RESET_PC;
      rf_we_q        <= 1'b0;
      dest_q         <= 5'd0;
      alu_result_q   <= 32'd0;
      res_from_mem_q <= 1'b0;
      load_op_q      <= 3'b000;
    end else begin
      me_valid_q     <= me_valid_d;
      pc_q           <= pc_d;
      rf_we_q        <= rf_we_d;
      dest_q         <= dest_d;
      alu_result_q   <= alu_result_d;
      res_from_mem_q <= res_from_mem_d;
      load_op_q      <= load_op_d;
    end
  end

  assign addr = alu_result_q[1:0];

  // Pick the addressed byte out of the returned word
  always_comb begin
    load_byte = bus_if.data_sram_rdata[7:0];
    case (addr)
      2'd0:    load_byte = bus_if.data_sram_rdata[7:0];
      2'd1:    load_byte = bus_if.data_sram_rdata[15:8];
      2'd2:    load_byte = bus_if.data_sram_rdata[23:16];
      default: load_byte = bus_if.data_sram_rdata[31:24];
    endcase
  end

  // Halfword select only looks at addr[1]; addr[0] is ignored for halfword loads
  always_comb begin
    load_half = addr[1] ? bus_if.data_sram_rdata[31:16] : bus_if.data_sram_rdata[15:0];
  end

  // Extend according to load type; unused encodings behave as a word load
  always_comb begin
    load_result = bus_if.data_sram_rdata;
    case (load_op_q)
      LD_W:    load_result = bus_if.data_sram_rdata;
      LD_B:    load_result = {{24{load_byte[7]}}, load_byte};
      LD_BU:   load_result = {24'd0, load_byte};
      LD_H:    load_result = {{16{load_half[15]}}, load_half};
      LD_HU:   load_result = {16'd0, load_half};
      default: load_result = bus_if.data_sram_rdata;
    endcase
  end

  assign final_result = res_from_mem_q ? load_result : alu_result_q;

  // A bubble must never present a write enable downstream
  assign bus_if.ME_to_WB_Bus = {pc_q, rf_we_q & me_valid_q, dest_q, final_result};

  // r0 is hardwired zero, so a write to it is never a hazard or a forward source
  assign wr_valid = me_valid_q & rf_we_q & (dest_q != 5'd0);

`ifdef ME_FWD_EN
  // Full forwarding: decode can take the loaded value directly
  assign bus_if.ME_to_ID_Bypass = {wr_valid, dest_q, final_result};
`else
  // Hazard detection only: decode stalls on a match, data field is unused
  assign bus_if.ME_to_ID_Bypass = {wr_valid, dest_q, 32'd0};
`endif

endmodule

// File: tb/tb_me_stage.sv
// tb/tb_me_stage.sv - self-checking bench for me_stage against a one-slot queue model
module tb_me_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic        rfm;
    logic [2:0]  op;
    logic [31:0] rd;
  } entry_t;

  logic clk;
  logic reset;
  me_stage_if bus_if ();

  me_stage #(.RESET_PC(32'h1c000000)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  entry_t      q[$];
  entry_t      last;
  logic [31:0] wb_log[$];

  logic        obs_valid;
  logic        obs_ready;
  logic [69:0] obs_wb;
  logic [37:0] obs_byp;

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic entry_t mk(input logic [31:0] pc, input logic rf_we, input logic [4:0] dest,
                                input logic [31:0] alu, input logic rfm, input logic [2:0] op,
                                input logic [31:0] rd);
    entry_t e;
    e.pc = pc; e.rf_we = rf_we; e.dest = dest; e.alu = alu; e.rfm = rfm; e.op = op; e.rd = rd;
    return e;
  endfunction

  // Result computed with plain arithmetic from the ISA load rules
  function automatic logic [31:0] model_result(input entry_t e);
    int unsigned a, w, v;
    a = e.alu % 4;
    w = e.rd;
    if (!e.rfm) return e.alu;
    case (e.op)
      3'd1: begin v = (w >> (8 * a)) % 256; if (v >= 128) v = v + 32'hFFFFFF00; return v; end
      3'd3: return (w >> (8 * a)) % 256;
      3'd2: begin v = (w >> (16 * (a / 2))) % 65536; if (v >= 32768) v = v + 32'hFFFF0000; return v; end
      3'd4: return (w >> (16 * (a / 2))) % 65536;
      default: return w;
    endcase
  endfunction

  function automatic entry_t reset_entry();
    return mk(32'h1c000000, 1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 32'd0);
  endfunction

  // One clock: drive inputs after negedge, check outputs, then advance the model at posedge
  task automatic cycle(input logic esv, input entry_t e, input logic wbr);
    logic        valid_exp, ready_exp, accept;
    logic [31:0] fr;
    logic [31:0] byp_lo;
    bus_if.ES_Valid        = esv;
    bus_if.EX_to_ME_Bus    = {e.pc, e.rf_we, e.dest, e.alu, e.rfm, e.op};
    bus_if.WB_Unit_Ready   = wbr;
    bus_if.data_sram_rdata = last.rd;
    #1;
    valid_exp = (q.size() != 0);
    ready_exp = !valid_exp || wbr;
    fr = model_result(last);
`ifdef ME_FWD_EN
    byp_lo = fr;
`else
    byp_lo = 32'd0;
`endif
    obs_valid = bus_if.ME_Valid;
    obs_ready = bus_if.ME_Unit_Ready;
    obs_wb    = bus_if.ME_to_WB_Bus;
    obs_byp   = bus_if.ME_to_ID_Bypass;
    chk("me_valid", {69'd0, obs_valid}, {69'd0, valid_exp});
    chk("unit_ready", {69'd0, obs_ready}, {69'd0, ready_exp});
    chk("wb_bus", obs_wb, {last.pc, last.rf_we & valid_exp, last.dest, fr});
    chk("bypass", {32'd0, obs_byp},
        {32'd0, valid_exp & last.rf_we & (last.dest != 5'd0), last.dest, byp_lo});
    @(posedge clk);
    accept = esv && (q.size() == 0 || wbr);
    if (q.size() != 0 && wbr) begin
      wb_log.push_back(q[0].pc);
      void'(q.pop_front());
    end
    if (accept) begin
      q.push_back(e);
      last = e;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input logic wbr);
    reset = 1'b1;
    bus_if.ES_Valid = 1'b0;
    bus_if.WB_Unit_Ready = wbr;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    last = reset_entry();
  endtask

  entry_t idle;
  entry_t e;

  initial begin
    reset = 1'b1;
    bus_if.ES_Valid = 1'b0;
    bus_if.EX_to_ME_Bus = '0;
    bus_if.WB_Unit_Ready = 1'b1;
    bus_if.data_sram_rdata = '0;
    idle = mk(32'hdeadbeef, 1'b1, 5'd31, 32'h0badf00d, 1'b1, 3'd1, 32'h0);
    last = reset_entry();
    repeat (3) @(posedge clk);
    @(negedge clk);
    do_reset(1'b1);

    // reset state
    cycle(1'b0, idle, 1'b1);
    chk("rst_valid", {69'd0, obs_valid}, 70'd0);
    chk("rst_ready", {69'd0, obs_ready}, 70'd1);
    chk("rst_pc", {38'd0, obs_wb[69:38]}, {38'd0, 32'h1c000000});
    chk("rst_rfwe", {69'd0, obs_wb[37]}, 70'd0);

    // ld.b, top byte 0x80
    cycle(1'b1, mk(32'h1c000010, 1'b1, 5'd5, 32'h00001003, 1'b1, 3'b001, 32'h80FF1234), 1'b1);
    cycle(1'b0, idle, 1'b1);
    chk("ldb_result", {38'd0, obs_wb[31:0]}, {38'd0, 32'hFFFFFF80});
    chk("ldb_rfwe", {69'd0, obs_wb[37]}, 70'd1);
    chk("ldb_dest", {65'd0, obs_wb[36:32]}, 70'd5);

    // ld.hu then ld.h on the upper half
    cycle(1'b1, mk(32'h1c000014, 1'b1, 5'd6, 32'h00002002, 1'b1, 3'b100, 32'hBEEF0000), 1'b1);
    cycle(1'b1, mk(32'h1c000018, 1'b1, 5'd6, 32'h00002002, 1'b1, 3'b010, 32'hBEEF0000), 1'b1);
    chk("ldhu_result", {38'd0, obs_wb[31:0]}, {38'd0, 32'h0000BEEF});
    cycle(1'b0, idle, 1'b1);
    chk("ldh_result", {38'd0, obs_wb[31:0]}, {38'd0, 32'hFFFFBEEF});

    // stall for three cycles with a new instruction waiting
    cycle(1'b1, mk(32'h1c000004, 1'b1, 5'd3, 32'h11111111, 1'b0, 3'd0, 32'h0), 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, mk(32'h1c000008, 1'b1, 5'd4, 32'h22222222, 1'b0, 3'd0, 32'h0), 1'b0);
      chk("stall_ready", {69'd0, obs_ready}, 70'd0);
      chk("stall_pc", {38'd0, obs_wb[69:38]}, {38'd0, 32'h1c000004});
    end
    cycle(1'b1, mk(32'h1c000008, 1'b1, 5'd4, 32'h22222222, 1'b0, 3'd0, 32'h0), 1'b1);
    chk("release_pc_old", {38'd0, obs_wb[69:38]}, {38'd0, 32'h1c000004});
    cycle(1'b0, idle, 1'b1);
    chk("release_pc_new", {38'd0, obs_wb[69:38]}, {38'd0, 32'h1c000008});

    // back-to-back ALU ops
    wb_log.delete();
    cycle(1'b1, mk(32'h1c000000, 1'b1, 5'd1, 32'h00000100, 1'b0, 3'd0, 32'h0), 1'b1);
    cycle(1'b1, mk(32'h1c000004, 1'b1, 5'd2, 32'h00000200, 1'b0, 3'd0, 32'h0), 1'b1);
    chk("b2b_v1", {69'd0, obs_valid}, 70'd1);
    cycle(1'b1, mk(32'h1c000008, 1'b1, 5'd3, 32'h00000300, 1'b0, 3'd0, 32'h0), 1'b1);
    chk("b2b_v2", {69'd0, obs_valid}, 70'd1);
    cycle(1'b0, idle, 1'b1);
    chk("b2b_v3", {69'd0, obs_valid}, 70'd1);
    chk("b2b_res3", {38'd0, obs_wb[31:0]}, {38'd0, 32'h00000300});
    chk("b2b_count", 70'(wb_log.size()), 70'd3);
    if (wb_log.size() == 3) begin
      chk("b2b_pc0", {38'd0, wb_log[0]}, {38'd0, 32'h1c000000});
      chk("b2b_pc1", {38'd0, wb_log[1]}, {38'd0, 32'h1c000004});
      chk("b2b_pc2", {38'd0, wb_log[2]}, {38'd0, 32'h1c000008});
    end

    // bypass: dest 7, then dest 0
    cycle(1'b1, mk(32'h1c000020, 1'b1, 5'd7, 32'h12345678, 1'b0, 3'd0, 32'h0), 1'b1);
    cycle(1'b1, mk(32'h1c000024, 1'b1, 5'd0, 32'h9abcdef0, 1'b0, 3'd0, 32'h0), 1'b1);
`ifdef ME_FWD_EN
    chk("byp_dest7", {32'd0, obs_byp}, {32'd0, 1'b1, 5'd7, 32'h12345678});
`else
    chk("byp_dest7", {32'd0, obs_byp}, {32'd0, 1'b1, 5'd7, 32'h00000000});
`endif
    cycle(1'b0, idle, 1'b1);
    chk("byp_dest0_wv", {69'd0, obs_byp[37]}, 70'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      e = mk(32'h1c000000 + 32'($urandom_range(0, 4095)) * 4, 1'($urandom), 5'($urandom),
             $urandom, 1'($urandom), 3'($urandom_range(0, 7)), $urandom);
      cycle(1'($urandom_range(0, 3) != 0), e, 1'($urandom_range(0, 3) != 0));
    end

    // reset in the middle of a stall discards the instruction
    cycle(1'b1, mk(32'h1c000040, 1'b1, 5'd9, 32'h5, 1'b0, 3'd0, 32'h0), 1'b1);
    cycle(1'b0, idle, 1'b0);
    chk("pre_rst_valid", {69'd0, obs_valid}, 70'd1);
    wb_log.delete();
    do_reset(1'b0);
    cycle(1'b0, idle, 1'b0);
    chk("post_rst_valid", {69'd0, obs_valid}, 70'd0);
    chk("post_rst_pc", {38'd0, obs_wb[69:38]}, {38'd0, 32'h1c000000});
    chk("post_rst_no_handoff", 70'(wb_log.size()), 70'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/me_stage.md
Name: me_stage

Overview:
- Memory-access pipeline stage. Sits between the execute stage (upstream) and the write-back unit (downstream).
- Registers the EX→ME bus under a valid/ready handshake.
- Aligns and sign/zero-extends load data returned by the synchronous data SRAM.
- Selects the final result and drives the 70-bit ME→WB bus, plus a register-bypass bus to the decode stage.

Parameters:
- RESET_PC, 32'h1c000000, reset value of the latched pc field.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ES_Valid  in  1  execute stage presents a valid instruction
- ME_Unit_Ready  out  1  this stage can accept the EX→ME bus this cycle
- EX_to_ME_Bus  in  74  {pc[73:42], rf_we[41], dest[40:36], alu_result[35:4], res_from_mem[3], load_op[2:0]}
- data_sram_rdata  in  32  SRAM read data, returned one cycle after the EX-stage request
- ME_Valid  out  1  valid instruction offered to write-back
- WB_Unit_Ready  in  1  write-back accepts this cycle
- ME_to_WB_Bus  out  70  {pc[69:38], rf_we[37], dest[36:32], final_result[31:0]}
- ME_to_ID_Bypass  out  38  {wr_valid[37], dest[36:32], final_result[31:0]}; layout depends on ME_FWD_EN

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, applied on posedge clk.
- Reset values:
  - me_valid = 0, so ME_Valid = 0.
  - Latched pc = RESET_PC; all other latched fields = 0.
  - ME_Unit_Ready = 1 in the first cycle after reset.
- ready_go is constant 1: SRAM data is valid during the cycle the instruction occupies ME.
- ME_Unit_Ready = ~me_valid | WB_Unit_Ready. This is combinational and must not depend on ES_Valid.
- ME_Valid = me_valid.
- Register update:
  - When ME_Unit_Ready: me_valid <= ES_Valid.
  - When ES_Valid & ME_Unit_Ready: bus register <= EX_to_ME_Bus.
  - Otherwise: hold. A stall (me_valid=1, WB_Unit_Ready=0) holds all fields and ME_Valid stays 1.
- Simultaneous handoff: accept from EX and hand off to WB in the same cycle. Back-to-back throughput is 1 instruction/cycle with no bubble.
- Load extraction uses addr = alu_result[1:0]:
  - load_op 000 (ld.w): the full word.
  - load_op 001 (ld.b): byte addr, sign-extended.
  - load_op 011 (ld.bu): byte addr, zero-extended.
  - load_op 010 (ld.h): half addr[1] (addr[0] ignored), sign-extended.
  - load_op 100 (ld.hu): half addr[1] (addr[0] ignored), zero-extended.
  - load_op 101–111: treated as ld.w.
- final_result = res_from_mem ? load_result : alu_result. Purely combinational from registered fields and data_sram_rdata.
- ME_to_WB_Bus rf_we field = latched rf_we & me_valid. A bubble never carries a write enable.
- While stalled, data_sram_rdata must be held stable by the memory side; this stage does not buffer it.
- Reset mid-stall: the instruction is discarded, me_valid=0 on the next cycle, and no ME_Valid pulse occurs.

Optional Feature:
- Macro: ME_FWD_EN.
- Defined:
  - ME_to_ID_Bypass = {me_valid & rf_we, dest, final_result}, so decode can forward the loaded value without stalling.
  - wr_valid = 0 when dest = 0.
- Undefined:
  - ME_to_ID_Bypass[31:0] is driven 0.
  - Only {wr_valid, dest} are meaningful; decode uses them for hazard stall detection only.
  - Port width is unchanged.

Test Plan:
- Reset with clk toggling → ME_Valid=0, ME_Unit_Ready=1, ME_to_WB_Bus pc=32'h1c000000, rf_we=0.
- ld.b:
  - Stimulus: ES_Valid=1, alu_result=32'h00001003, res_from_mem=1, load_op=001, dest=5; next cycle data_sram_rdata=32'h80FF1234.
  - Required: final_result=32'hFFFFFF80, rf_we=1, dest=5.
- ld.hu at addr 0x..2 with rdata 32'hBEEF0000 → final_result 32'h0000BEEF. ld.h with the same inputs → 32'hFFFFBEEF.
- Stall:
  - Stimulus: WB_Unit_Ready=0 for 3 cycles with me_valid=1 and ES_Valid=1 (new pc 0x1c000008).
  - Required: ME_Unit_Ready=0, bus holds the old pc for 3 cycles; the new pc appears the cycle after WB_Unit_Ready rises.
- Back-to-back ALU ops:
  - Stimulus: pcs 0x1c000000/04/08, WB_Unit_Ready=1.
  - Required: ME_Valid high 3 consecutive cycles, pcs in order, final_result=alu_result.
- Bypass:
  - ME_FWD_EN defined, rf_we=1, dest=0 → wr_valid=0.
  - ME_FWD_EN defined, dest=7, result 32'h12345678 → bypass = {1, 7, 32'h12345678}.
  - ME_FWD_EN undefined → bypass[31:0]=0.
